lockin_integrate_dump: RTL and testbench

//  Integrate-and-dump low-pass stage of the lock-in demodulator.
//  - Accumulates signed mixer products over a programmable number of accepted samples.
//  - Emits one wide signed sum per window, with a one-cycle valid strobe.
//  - Output feeds the 64->32 bit saturating slice stage directly downstream.

---
 rtl/lockin_pkg.sv | 11 +
 rtl/lockin_sat_add.sv | 30 +++
 rtl/lockin_integrate_dump.sv | 77 +++++++
 tb/tb_lockin_integrate_dump.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/lockin_pkg.sv
// Shared constants for the lock-in demodulator accumulator chain.
package lockin_pkg;

  localparam int LI_WIN   = 32;
  localparam int LI_WOUT  = 64;
  localparam int LI_CNT_W = 32;

  localparam logic signed [LI_WOUT-1:0] LI_SAT_MAX = {1'b0, {(LI_WOUT-1){1'b1}}};
  localparam logic signed [LI_WOUT-1:0] LI_SAT_MIN = {1'b1, {(LI_WOUT-1){1'b0}}};

endpackage

// File: rtl/lockin_sat_add.sv
// Combinational signed saturating adder shared by the lock-in accumulators.
module lockin_sat_add
  import lockin_pkg::*;
#(
  parameter int w = LI_WOUT
) (
  input  logic signed [w-1:0] a,
  input  logic signed [w-1:0] b,
  output logic signed [w-1:0] sum,
  output logic                ovf
);

  localparam logic signed [w-1:0] SAT_MAX = {1'b0, {(w-1){1'b1}}};
  localparam logic signed [w-1:0] SAT_MIN = {1'b1, {(w-1){1'b0}}};

  // Overflow is only possible when both operands share a sign and the result flips it.
  function automatic logic [w:0] sat_add(input logic signed [w-1:0] x,
                                         input logic signed [w-1:0] y);
    logic signed [w-1:0] raw;
    raw = x + y;
    if (!x[w-1] && !y[w-1] && raw[w-1])
      return {1'b1, SAT_MAX};
    else if (x[w-1] && y[w-1] && !raw[w-1])
      return {1'b1, SAT_MIN};
    return {1'b0, raw};
  endfunction

  assign {ovf, sum} = sat_add(a, b);

endmodule

// File: rtl/lockin_integrate_dump.sv
// Integrate-and-dump low-pass stage: sums a programmable number of accepted samples per window.
module lockin_integrate_dump
  import lockin_pkg::*;
#(
  parameter int win   = LI_WIN,
  parameter int wout  = LI_WOUT,
  parameter int cnt_w = LI_CNT_W
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic signed [win-1:0]  sig_i,
  input  logic                   valid_i,
  input  logic [cnt_w-1:0]       period_i,
  input  logic                   clear_i,
  output logic signed [wout-1:0] sig_o,
  output logic                   valid_o,
  output logic                   ovf_o
);

  logic signed [wout-1:0] acc;
  logic signed [wout-1:0] sig_ext;
  logic signed [wout-1:0] sum;
  logic                   add_ovf;
  logic [cnt_w-1:0]       cnt;
  logic [cnt_w-1:0]       per_q;
  logic [cnt_w-1:0]       per_eff;
  logic [cnt_w-1:0]       per_cur;
  logic                   last;

  assign sig_ext = wout'(sig_i);

  lockin_sat_add #(.w(wout)) u_sat_add (
    .a   (acc),
    .b   (sig_ext),
    .sum (sum),
    .ovf (add_ovf)
  );

  // The first sample of a window sees the period being latched, not the stale one.
  assign per_eff = (period_i == '0) ? cnt_w'(1) : period_i;
  assign per_cur = (cnt == '0) ? per_eff : per_q;
  assign last    = (cnt == per_cur - cnt_w'(1));

  // Accumulate / dump stage boundary: all outputs registered here.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc     <= '0;
      cnt     <= '0;
      per_q   <= cnt_w'(1);
      sig_o   <= '0;
      valid_o <= 1'b0;
      ovf_o   <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (clear_i) begin
        acc   <= '0;
        cnt   <= '0;
        ovf_o <= 1'b0;
      end else if (valid_i) begin
        if (cnt == '0)
          per_q <= per_eff;
        if (add_ovf)
          ovf_o <= 1'b1;
        if (last) begin
          sig_o   <= sum;
          valid_o <= 1'b1;
          acc     <= '0;
          cnt     <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + cnt_w'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_lockin_integrate_dump.sv
// Directed bench for lockin_integrate_dump: full-width instance plus a narrow-accumulator instance.
module tb_lockin_integrate_dump;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic signed [31:0] sig_b    = '0;
  logic               valid_b  = 1'b0;
  logic               clear_b  = 1'b0;
  logic [31:0]        period_b = '0;
  logic signed [63:0] sigo_b;
  logic               valido_b;
  logic               ovf_b;

  logic signed [7:0]  sig_s    = '0;
  logic               valid_s  = 1'b0;
  logic               clear_s  = 1'b0;
  logic [7:0]         period_s = '0;
  logic signed [9:0]  sigo_s;
  logic               valido_s;
  logic               ovf_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lockin_integrate_dump u_big (
    .clk_i    (clk),
    .rst_i    (rst),
    .sig_i    (sig_b),
    .valid_i  (valid_b),
    .period_i (period_b),
    .clear_i  (clear_b),
    .sig_o    (sigo_b),
    .valid_o  (valido_b),
    .ovf_o    (ovf_b)
  );

  // Narrow accumulator so that saturation is reachable within a few samples.
  lockin_integrate_dump #(.win(8), .wout(10), .cnt_w(8)) u_small (
    .clk_i    (clk),
    .rst_i    (rst),
    .sig_i    (sig_s),
    .valid_i  (valid_s),
    .period_i (period_s),
    .clear_i  (clear_s),
    .sig_o    (sigo_s),
    .valid_o  (valido_s),
    .ovf_o    (ovf_s)
  );

  typedef struct {
    logic signed [127:0] acc;
    logic [63:0]         n;
    logic [63:0]         per;
    logic signed [127:0] sig;
    logic                vld;
    logic                ovf;
  } mdl_t;

  localparam logic signed [127:0] MAX_B = 128'sh7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [127:0] MIN_B = -MAX_B - 128'sd1;
  localparam logic signed [127:0] MAX_S = 128'sd511;
  localparam logic signed [127:0] MIN_S = -128'sd512;

  mdl_t mb;
  mdl_t ms;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Window model on wide integers: count accepted samples, clamp the running total.
  function automatic mdl_t model_step(input mdl_t m, input logic r, input logic c, input logic v,
                                      input logic signed [127:0] x, input logic [63:0] p,
                                      input logic signed [127:0] mx, input logic signed [127:0] mn);
    mdl_t o;
    logic signed [127:0] s;
    o = m;
    if (r) begin
      o.acc = '0; o.n = '0; o.per = 64'd1; o.sig = '0; o.vld = 1'b0; o.ovf = 1'b0;
      return o;
    end
    o.vld = 1'b0;
    if (c) begin
      o.acc = '0; o.n = '0; o.ovf = 1'b0;
    end else if (v) begin
      if (o.n == 0) o.per = (p == 0) ? 64'd1 : p;
      s = o.acc + x;
      if (s > mx) begin s = mx; o.ovf = 1'b1; end
      else if (s < mn) begin s = mn; o.ovf = 1'b1; end
      o.n = o.n + 64'd1;
      if (o.n == o.per) begin
        o.sig = s; o.vld = 1'b1; o.acc = '0; o.n = '0;
      end else begin
        o.acc = s;
      end
    end
    return o;
  endfunction

  always @(posedge clk) begin
    mb = model_step(mb, rst, clear_b, valid_b, 128'(sig_b), 64'(period_b), MAX_B, MIN_B);
    ms = model_step(ms, rst, clear_s, valid_s, 128'(sig_s), 64'(period_s), MAX_S, MIN_S);
    #1;
    check("model big sig_o",     128'(sigo_b),   mb.sig);
    check("model big valid_o",   {127'd0, valido_b}, {127'd0, mb.vld});
    check("model big ovf_o",     {127'd0, ovf_b},    {127'd0, mb.ovf});
    check("model small sig_o",   128'(sigo_s),   ms.sig);
    check("model small valid_o", {127'd0, valido_s}, {127'd0, ms.vld});
    check("model small ovf_o",   {127'd0, ovf_s},    {127'd0, ms.ovf});
  end

  task automatic step(input logic r, input bit sel, input logic c, input logic v,
                      input logic signed [31:0] s, input logic [31:0] p);
    rst = r;
    if (!sel) begin
      clear_b = c; valid_b = v; sig_b = s; period_b = p;
      clear_s = 1'b0; valid_s = 1'b0;
    end else begin
      clear_s = c; valid_s = v; sig_s = s[7:0]; period_s = p[7:0];
      clear_b = 1'b0; valid_b = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic bs(input logic v, input logic signed [31:0] s, input logic [31:0] p);
    step(1'b0, 1'b0, 1'b0, v, s, p);
  endtask

  task automatic ss(input logic v, input logic signed [31:0] s, input logic [31:0] p);
    step(1'b0, 1'b1, 1'b0, v, s, p);
  endtask

  task automatic chk_big(input string name, input logic v, input logic [63:0] s, input logic o);
    check({name, " valid_o"}, {127'd0, valido_b}, {127'd0, v});
    check({name, " sig_o"},   {64'd0, sigo_b},    {64'd0, s});
    check({name, " ovf_o"},   {127'd0, ovf_b},    {127'd0, o});
  endtask

  task automatic chk_small(input string name, input logic v, input logic [9:0] s, input logic o);
    check({name, " valid_o"}, {127'd0, valido_s}, {127'd0, v});
    check({name, " sig_o"},   {118'd0, sigo_s},   {118'd0, s});
    check({name, " ovf_o"},   {127'd0, ovf_s},    {127'd0, o});
  endtask

  initial begin
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    chk_big("reset big", 1'b0, 64'd0, 1'b0);
    chk_small("reset small", 1'b0, 10'd0, 1'b0);
    bs(1'b0, 0, 4);

    // period 4, samples 1..4
    bs(1'b1, 1, 4); bs(1'b1, 2, 4); bs(1'b1, 3, 4);
    chk_big("t1 before dump", 1'b0, 64'd0, 1'b0);
    bs(1'b1, 4, 4);
    chk_big("t1 dump", 1'b1, 64'd10, 1'b0);
    bs(1'b0, 0, 4);
    chk_big("t1 hold", 1'b0, 64'd10, 1'b0);

    // period 3, gapped -5 samples
    bs(1'b1, -5, 3); bs(1'b0, -5, 3); bs(1'b0, -5, 3);
    bs(1'b1, -5, 3); bs(1'b0, -5, 3);
    chk_big("t2 gap", 1'b0, 64'd10, 1'b0);
    bs(1'b1, -5, 3);
    chk_big("t2 dump", 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);

    // period 0 and 1 dump every sample
    bs(1'b1, 32'sh8000_0000, 0);
    chk_big("t3 p0 a", 1'b1, 64'hFFFF_FFFF_8000_0000, 1'b0);
    bs(1'b1, 32'sh8000_0000, 0);
    chk_big("t3 p0 b", 1'b1, 64'hFFFF_FFFF_8000_0000, 1'b0);
    bs(1'b1, 32'sh8000_0000, 1);
    chk_big("t3 p1", 1'b1, 64'hFFFF_FFFF_8000_0000, 1'b0);
    bs(1'b0, 0, 1);
    chk_big("t3 idle", 1'b0, 64'hFFFF_FFFF_8000_0000, 1'b0);

    // clear discards a partial window and a coincident sample
    bs(1'b1, 7, 4); bs(1'b1, 7, 4);
    step(1'b0, 1'b0, 1'b1, 1'b1, 7, 4);
    chk_big("t5 clear", 1'b0, 64'hFFFF_FFFF_8000_0000, 1'b0);
    bs(1'b1, 1, 4); bs(1'b1, 1, 4); bs(1'b1, 1, 4);
    chk_big("t5 partial", 1'b0, 64'hFFFF_FFFF_8000_0000, 1'b0);
    bs(1'b1, 1, 4);
    chk_big("t5 dump", 1'b1, 64'd4, 1'b0);

    // period change mid-window, then reset mid-window
    bs(1'b1, 10, 2); bs(1'b1, 20, 5);
    chk_big("t6 dump p2", 1'b1, 64'd30, 1'b0);
    bs(1'b1, 1, 5); bs(1'b1, 1, 5);
    chk_big("t6 p5 no early dump", 1'b0, 64'd30, 1'b0);
    bs(1'b1, 1, 5); bs(1'b1, 1, 5);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1, 5);
    chk_big("t6 reset", 1'b0, 64'd0, 1'b0);
    bs(1'b0, 0, 5); bs(1'b0, 0, 5);
    chk_big("t6 after reset", 1'b0, 64'd0, 1'b0);
    bs(1'b1, 2, 5); bs(1'b1, 2, 5); bs(1'b1, 2, 5); bs(1'b1, 2, 5);
    chk_big("t6 p5 partial", 1'b0, 64'd0, 1'b0);
    bs(1'b1, 2, 5);
    chk_big("t6 p5 dump", 1'b1, 64'd10, 1'b0);

    // saturation on the narrow instance
    ss(1'b1, 127, 7); ss(1'b1, 127, 7); ss(1'b1, 127, 7); ss(1'b1, 127, 7);
    chk_small("t4 pre-sat", 1'b0, 10'd0, 1'b0);
    ss(1'b1, 127, 7);
    chk_small("t4 sat", 1'b0, 10'd0, 1'b1);
    ss(1'b1, -128, 7); ss(1'b1, -128, 7);
    chk_small("t4 dump from clamp", 1'b1, 10'h0FF, 1'b1);
    ss(1'b1, 1, 2); ss(1'b1, 1, 2);
    chk_small("t4 sticky", 1'b1, 10'd2, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 0, 2);
    chk_small("t4 clear", 1'b0, 10'd2, 1'b0);
    ss(1'b1, -128, 5); ss(1'b1, -128, 5); ss(1'b1, -128, 5); ss(1'b1, -128, 5);
    ss(1'b1, -128, 5);
    chk_small("t4 neg sat", 1'b1, 10'h200, 1'b1);
    ss(1'b0, 0, 5); ss(1'b0, 0, 5);
    chk_small("t4 neg hold", 1'b0, 10'h200, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
